arm_mem_access: RTL and testbench
=================================

Name: arm_mem_access

Overview:
Load/store initiator that drives one port of the dual-port word memory (arm_memory) on behalf of the CPU datapath.
- Accepts byte, halfword and word load/store requests over a valid/ready handshake.
- Performs alignment checks and little-endian lane selection.
- Sign- or zero-extends loads.
- Implements sub-word stores as read-modify-write, since the memory is word-write only.
- Returns one response per request with a fault code.

Parameters:
- ADDR_W, 32, byte address width of the request and memory ports.
- DATA_W, 32, data width; fixed at 32, and lane logic assumes 4 byte lanes.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved
- req_signed  in  1  sign-extend load (ignored for word and for stores)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified for sub-word
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  2  00 = ok, 01 = alignment/reserved size, 10 = memory exception
- mem_addr  out  32  word-aligned address to memory port
- mem_data_in  out  32  write data to memory port
- mem_we  out  1  memory write enable
- mem_data_out  in  32  read data from memory, valid one cycle after address
- mem_excpt  in  1  memory exception, valid one cycle after address

Behaviour:
- Reset (async, any state): state = IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_fault=00; mem_we=0, mem_addr=0, mem_data_in=0. Any in-flight request is dropped and produces no response.
- Accept: on a rising edge with req_valid & req_ready, latch write, size, signed, addr and wdata. Inputs are ignored in all other states.
- Fault check at accept: size=11, half with addr[0]=1, or word with addr[1:0]≠0 → go to RESP with fault=01. No memory access occurs.
- States and transitions:
  - IDLE → RD_ISSUE (load or sub-word store) | WR_ISSUE (word store) | RESP (align fault).
  - RD_ISSUE: mem_addr={addr[31:2],00}, mem_we=0. → RD_DATA.
  - RD_DATA: mem_addr held; sample mem_data_out and mem_excpt at the edge.
    - excpt → RESP, fault=10; no write for a sub-word store.
    - load → RESP.
    - sub-word store → WR_ISSUE with merged word.
  - WR_ISSUE: mem_addr aligned, mem_we=1 for exactly one cycle. mem_data_in = req_wdata (word store) or read word with the addressed byte/half lane replaced by wdata[7:0]/wdata[15:0]. → WR_CHK.
  - WR_CHK: mem_we=0, mem_addr held; sample mem_excpt → fault=10 if set. → RESP.
  - RESP: rsp_valid=1 for one cycle, with no backpressure. → IDLE.
- Lane select (little-endian):
  - byte lane = addr[1:0]; half lane = addr[1].
  - Load extension uses bit 7/15 of the selected lane when req_signed=1, else zero-fill.
- Latency from the accept edge to rsp_valid high:
  - align fault: 1 cycle
  - load or word store: 3 cycles
  - sub-word store: 5 cycles
- Throughput: one request outstanding; req_ready=0 from the accept edge until the cycle after RESP.
- Outside RD_ISSUE..WR_CHK: mem_addr=0, mem_data_in=0, mem_we=0.
- rsp_rdata and rsp_fault are meaningful only while rsp_valid=1, and are cleared to 0 otherwise.

Test Plan:
1. Word store 0x1f1e803b @0x10, then word load @0x10 → exactly one mem_we pulse with addr 0x10; load rsp_rdata=0x1f1e803b, fault=00, rsp_valid 3 cycles after accept.
2. After 1: byte unsigned @0x13 → 0x0000001f; half signed @0x12 → 0x00001f1e; half signed @0x10 → 0xffff803b; byte signed @0x11 → 0xffffff80.
3. Byte store 0xAA @0x11 after 1 → read then one write with mem_data_in=0x1f1eaa3b; rsp_valid 5 cycles after accept; subsequent word load returns 0x1f1eaa3b.
4. Word load @0x12, half store @0x13, size=11 @0x10 → each gives fault=01 one cycle after accept; mem_we stays 0 and mem_addr stays 0.
5. Half store @ an address that drives mem_excpt=1 → fault=10, no mem_we pulse; word load at the same address → fault=10, rsp_rdata=0.
6. Assert rst_n=0 during WR_ISSUE of a sub-word store → mem_we falls immediately, no rsp_valid; after release, req_ready=1 and a new word load completes normally.

Source files
------------

// File: rtl/arm_mem_access.sv
// Load/store initiator for one port of a word-write-only memory.
// Handles byte/half/word accesses with little-endian lane selection, load
// sign/zero extension and read-modify-write for sub-word stores.
module arm_mem_access #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_excpt
);

    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_HALF   = 2'b01;
    localparam logic [1:0] SIZE_WORD   = 2'b10;
    localparam logic [1:0] SIZE_RSVD   = 2'b11;
    localparam logic [1:0] FAULT_OK    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_MEM   = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_DATA  = 3'd2,
        WR_ISSUE = 3'd3,
        WR_CHK   = 3'd4,
        RESP     = 3'd5
    } state_t;

    typedef struct packed {
        logic              write;
        logic [1:0]        size;
        logic              sgn;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state;
    state_t            state_next;
    req_t              req_q;

    logic              align_fault_c;
    logic [ADDR_W-1:0] addr_src_c;
    logic [ADDR_W-1:0] addr_aligned_c;

    logic              req_ready_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic [1:0]        rsp_fault_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_data_in_d;
    logic              mem_we_d;

    // Extract the addressed lane from a memory word and extend it.
    function automatic logic [DATA_W-1:0] load_ext(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        size,
        input logic              sgn,
        input logic [1:0]        lane
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: load_ext = {{24{sgn & b[7]}}, b};
            SIZE_HALF: load_ext = {{16{sgn & h[15]}}, h};
            default:   load_ext = word;
        endcase
    endfunction

    // Replace the addressed byte/half lane of a read word with store data.
    function automatic logic [DATA_W-1:0] merge_store(
        input logic [DATA_W-1:0] word,
        input logic [DATA_W-1:0] wdata,
        input logic [1:0]        size,
        input logic [1:0]        lane
    );
        merge_store = word;
        if (size == SIZE_BYTE) begin
            case (lane)
                2'd0:    merge_store[7:0]   = wdata[7:0];
                2'd1:    merge_store[15:8]  = wdata[7:0];
                2'd2:    merge_store[23:16] = wdata[7:0];
                default: merge_store[31:24] = wdata[7:0];
            endcase
        end else if (lane[1]) begin
            merge_store[31:16] = wdata[15:0];
        end else begin
            merge_store[15:0] = wdata[15:0];
        end
    endfunction

    // Alignment / reserved-size check on the incoming request.
    always_comb begin
        align_fault_c = (req_size == SIZE_RSVD) ||
                        ((req_size == SIZE_HALF) && req_addr[0]) ||
                        ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
    end

    // Address in play: live request at accept, latched request afterwards.
    always_comb begin
        addr_src_c     = (state == IDLE) ? req_addr : req_q.addr;
        addr_aligned_c = {addr_src_c[ADDR_W-1:2], 2'b00};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (align_fault_c) begin
                        state_next = RESP;
                    end else if (req_write && (req_size == SIZE_WORD)) begin
                        state_next = WR_ISSUE;
                    end else begin
                        state_next = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: state_next = RD_DATA;
            RD_DATA: begin
                if (mem_excpt || !req_q.write) begin
                    state_next = RESP;
                end else begin
                    state_next = WR_ISSUE;
                end
            end
            WR_ISSUE: state_next = WR_CHK;
            WR_CHK:   state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Output values for the state being entered; registered below.
    always_comb begin
        req_ready_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_fault_d   = FAULT_OK;
        mem_addr_d    = '0;
        mem_data_in_d = '0;
        mem_we_d      = 1'b0;
        case (state_next)
            IDLE: req_ready_d = 1'b1;
            RD_ISSUE, RD_DATA, WR_CHK: mem_addr_d = addr_aligned_c;
            WR_ISSUE: begin
                mem_addr_d = addr_aligned_c;
                mem_we_d   = 1'b1;
                if (state == IDLE) begin
                    mem_data_in_d = req_wdata;
                end else begin
                    mem_data_in_d = merge_store(mem_data_out, req_q.wdata,
                                                req_q.size, req_q.addr[1:0]);
                end
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                if (state == IDLE) begin
                    rsp_fault_d = FAULT_ALIGN;
                end else if (mem_excpt) begin
                    rsp_fault_d = FAULT_MEM;
                end else if (state == RD_DATA) begin
                    rsp_rdata_d = load_ext(mem_data_out, req_q.size,
                                           req_q.sgn, req_q.addr[1:0]);
                end
            end
            default: ;
        endcase
    end

    // Latch the request on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else if ((state == IDLE) && req_valid) begin
            req_q <= '{write: req_write, size: req_size, sgn: req_signed,
                       addr: req_addr, wdata: req_wdata};
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_fault   <= FAULT_OK;
            mem_addr    <= '0;
            mem_data_in <= '0;
            mem_we      <= 1'b0;
        end else begin
            req_ready   <= req_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_fault   <= rsp_fault_d;
            mem_addr    <= mem_addr_d;
            mem_data_in <= mem_data_in_d;
            mem_we      <= mem_we_d;
        end
    end

endmodule

// File: tb/tb_arm_mem_access.sv
// Bench for arm_mem_access: word memory environment with an exception
// region (address bit 12), a reference model of expected responses and
// memory writes, and a per-cycle compare process.
module tb_arm_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_we;
    logic [31:0] mem_data_out = 32'h0;
    logic        mem_excpt = 1'b0;

    arm_mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we(mem_we),
        .mem_data_out(mem_data_out), .mem_excpt(mem_excpt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_we = 0;
    int last_acc_cyc = 0;
    int last_rsp_cyc = 0;
    logic [31:0] last_rdata = 32'h0;
    logic [1:0]  last_fault = 2'b0;
    logic [31:0] last_wr_data = 32'h0;

    typedef struct { int due; logic [31:0] rdata; logic [1:0] fault; } rsp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    logic [31:0] env_mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory environment: registered read data and exception, word writes.
    always @(posedge clk) begin
        mem_excpt <= mem_addr[12];
        if (mem_addr[12]) mem_data_out <= 32'h0;
        else mem_data_out <= env_mem.exists(mem_addr[31:2]) ? env_mem[mem_addr[31:2]] : 32'h0;
        if (mem_we && !mem_addr[12]) env_mem[mem_addr[31:2]] = mem_data_in;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [29:0] k);
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    // Reference model: outcome of one request from the access rules.
    function automatic void model(input bit w, input logic [1:0] sz, input bit sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output int lat, output logic [31:0] rdata,
                                  output logic [1:0] fault, output bit has_wr,
                                  output logic [31:0] wr_data);
        logic [31:0] wrd, mask, v;
        int sh;
        bit exc;
        lat = 3; rdata = 32'h0; fault = 2'b00; has_wr = 0; wr_data = 32'h0;
        if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) begin
            lat = 1; fault = 2'b01;
            return;
        end
        exc = a[12];
        wrd = ref_rd(a[31:2]);
        sh = (sz == 2'b00) ? int'(a[1:0]) * 8 : int'(a[1]) * 16;
        mask = (sz == 2'b00) ? 32'hff : 32'hffff;
        if (!w) begin
            if (exc) fault = 2'b10;
            else if (sz == 2'b10) rdata = wrd;
            else begin
                v = (wrd >> sh) & mask;
                if (sg && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
                rdata = v;
            end
        end else if (sz == 2'b10) begin
            has_wr = 1; wr_data = wd;
            if (exc) fault = 2'b10;
            else ref_mem[a[31:2]] = wd;
        end else if (exc) begin
            fault = 2'b10;
        end else begin
            lat = 5; has_wr = 1;
            wr_data = (wrd & ~(mask << sh)) | ((wd & mask) << sh);
            ref_mem[a[31:2]] = wr_data;
        end
    endfunction

    // Per-cycle compare of every DUT output against the expected queues.
    always @(negedge clk) begin : cmp
        bit quiet;
        if (rst_n) begin
            quiet = (rsp_q.size() == 0) || (rsp_q[0].due == cyc);
            chk("req_ready", 32'(req_ready), 32'(rsp_q.size() == 0));
            if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
                chk("rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rsp_rdata", rsp_rdata, rsp_q[0].rdata);
                chk("rsp_fault", 32'(rsp_fault), 32'(rsp_q[0].fault));
                last_rdata = rsp_rdata;
                last_fault = rsp_fault;
                last_rsp_cyc = cyc;
                void'(rsp_q.pop_front());
            end else begin
                chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
                chk("rsp_data_idle", rsp_rdata | 32'(rsp_fault), 32'd0);
            end
            if (mem_we) begin
                n_we++;
                last_wr_data = mem_data_in;
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_we: unexpected write addr %h data %h (cycle %0d)",
                             mem_addr, mem_data_in, cyc);
                end else begin
                    chk("mem_wr_addr", mem_addr, wr_q[0].addr);
                    chk("mem_wr_data", mem_data_in, wr_q[0].data);
                    void'(wr_q.pop_front());
                end
            end
            if (quiet) chk("mem_quiet", mem_addr | mem_data_in | 32'(mem_we), 32'd0);
        end
    end

    task automatic garbage();
        req_write  = 1'($urandom_range(0, 1));
        req_size   = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic do_req(input bit w, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd);
        int n;
        int lat;
        logic [31:0] rd, wrd;
        logic [1:0] f;
        bit hw;
        rsp_t r;
        wr_t  x;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            req_valid = 1'($urandom_range(0, 1));
            garbage();
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
            req_valid = 0;
            return;
        end
        req_valid = 1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 0;
        garbage();
        model(w, sz, sg, a, wd, lat, rd, f, hw, wrd);
        last_acc_cyc = cyc;
        r.due = cyc + lat - 1; r.rdata = rd; r.fault = f;
        rsp_q.push_back(r);
        if (hw) begin
            x.addr = {a[31:2], 2'b00}; x.data = wrd;
            wr_q.push_back(x);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (rsp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (rsp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got no response expected one (cycle %0d)", cyc);
            rsp_q.delete();
        end
    endtask

    task automatic req_chk(input string name, input bit w, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic [1:0] exp_f, input int exp_lat);
        do_req(w, sz, sg, a, wd);
        wait_idle();
        chk({name, "_rdata"}, last_rdata, exp_rd);
        chk({name, "_fault"}, 32'(last_fault), 32'(exp_f));
        chk({name, "_latency"}, 32'(last_rsp_cyc - last_acc_cyc + 1), 32'(exp_lat));
    endtask

    initial begin
        int we0;
        int n;
        logic [31:0] old;
        bit w, sg;
        logic [1:0] sz;
        logic [31:0] a;
        int r;

        rst_n = 0; req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp", 32'(rsp_valid) | rsp_rdata | 32'(rsp_fault), 32'd0);
        chk("reset_mem", mem_addr | mem_data_in | 32'(mem_we), 32'd0);
        #2 rst_n = 1;

        // Word store then word load.
        we0 = n_we;
        req_chk("t1_st", 1, 2'b10, 0, 32'h10, 32'h1f1e803b, 32'h0, 2'b00, 3);
        chk("t1_st_wdata", last_wr_data, 32'h1f1e803b);
        req_chk("t1_ld", 0, 2'b10, 0, 32'h10, 32'h0, 32'h1f1e803b, 2'b00, 3);
        chk("t1_we_count", 32'(n_we - we0), 32'd1);

        // Sub-word loads with extension.
        req_chk("t2_bu13", 0, 2'b00, 0, 32'h13, 0, 32'h0000001f, 2'b00, 3);
        req_chk("t2_hs12", 0, 2'b01, 1, 32'h12, 0, 32'h00001f1e, 2'b00, 3);
        req_chk("t2_hs10", 0, 2'b01, 1, 32'h10, 0, 32'hffff803b, 2'b00, 3);
        req_chk("t2_bs11", 0, 2'b00, 1, 32'h11, 0, 32'hffffff80, 2'b00, 3);

        // Byte store via read-modify-write.
        req_chk("t3_sb", 1, 2'b00, 0, 32'h11, 32'h000000aa, 32'h0, 2'b00, 5);
        chk("t3_merge", last_wr_data, 32'h1f1eaa3b);
        req_chk("t3_ld", 0, 2'b10, 0, 32'h10, 0, 32'h1f1eaa3b, 2'b00, 3);

        // Alignment / reserved-size faults.
        we0 = n_we;
        req_chk("t4_lw12", 0, 2'b10, 0, 32'h12, 0, 32'h0, 2'b01, 1);
        req_chk("t4_sh13", 1, 2'b01, 0, 32'h13, 32'h1234, 32'h0, 2'b01, 1);
        req_chk("t4_rsvd", 0, 2'b11, 0, 32'h10, 0, 32'h0, 2'b01, 1);
        chk("t4_no_we", 32'(n_we - we0), 32'd0);

        // Memory exception region.
        we0 = n_we;
        req_chk("t5_sh", 1, 2'b01, 0, 32'h1010, 32'hbeef, 32'h0, 2'b10, 3);
        chk("t5_no_we", 32'(n_we - we0), 32'd0);
        req_chk("t5_lw", 0, 2'b10, 0, 32'h1010, 0, 32'h0, 2'b10, 3);

        // Reset in the middle of a sub-word store's write cycle.
        req_chk("t6_init", 1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 2'b00, 3);
        old = ref_rd(30'h8);
        do_req(1, 2'b00, 0, 32'h21, 32'h55);
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            #2;
            n++;
            if (mem_we) break;
        end
        chk("t6_in_wr_issue", 32'(mem_we), 32'd1);
        rst_n = 0;
        #1;
        chk("t6_we_drop", 32'(mem_we), 32'd0);
        chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
        chk("t6_ready", 32'(req_ready), 32'd1);
        rsp_q.delete();
        wr_q.delete();
        ref_mem[30'h8] = old;
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        req_chk("t6_ld", 0, 2'b10, 0, 32'h20, 0, 32'h11223344, 2'b00, 3);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            w  = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 7));
            sz = (r < 7) ? 2'(r % 3) : 2'b11;
            a  = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 63))
                                             : 32'($urandom_range(0, 63));
            do_req(w, sz, sg, a, $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        wait_idle();
        repeat (2) @(negedge clk);
        chk("writes_drained", 32'(wr_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
